nfc_cmd_scheduler: RTL and testbench



---
 rtl/nfc_cmd_scheduler_if.sv | 20 ++
 rtl/nfc_cmd_scheduler.sv | 160 ++++++++++++++++
 tb/tb_nfc_cmd_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nfc_cmd_scheduler_if.sv
// Command port between the NAND command scheduler (master) and the NFC core (slave).
interface nfc_cmd_scheduler_if;
  logic [31:0] oCmd;
  logic [31:0] oAddr;
  logic [15:0] oLen;
  logic        oCmdValid;
  logic        iCmdReady;
  logic        iCmdDone;
  logic        iCmdFail;

  modport master (
    output oCmd, oAddr, oLen, oCmdValid,
    input  iCmdReady, iCmdDone, iCmdFail
  );

  modport slave (
    input  oCmd, oAddr, oLen, oCmdValid,
    output iCmdReady, iCmdDone, iCmdFail
  );
endinterface

// File: rtl/nfc_cmd_scheduler.sv
// Queues host NAND commands and issues them one at a time to the NFC core.
// Define NFC_SCHED_TIMEOUT_EN to build the WAIT-state watchdog (oTimeout/oAbort).
module nfc_cmd_scheduler #(
  parameter int                   FIFO_AW        = 3,
  parameter int                   TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          iCommand,
  input  logic [31:0]          iAddress,
  input  logic [15:0]          iLength,
  input  logic                 iCommandValid,
  input  logic                 iFlush,
  input  logic                 iClear,
  nfc_cmd_scheduler_if.master  core,
  output logic                 oBusy,
  output logic [FIFO_AW:0]     oQueueCount,
  output logic                 oQueueFull,
  output logic                 oOverflow,
  output logic                 oFail,
  output logic [31:0]          oFailCmd,
  output logic                 oTimeout,
  output logic                 oAbort,
  output logic [15:0]          oDoneCount
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state;
  state_t              state_next;
  logic [79:0]         mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr;
  logic [FIFO_AW-1:0]  rd_ptr;
  logic                push;
  logic                pop;
  logic                overflow_set;
  logic                handshake;
  logic                done_evt;
  logic                fail_evt;
  logic                abort_evt;
  logic                wdog_expired;

  // Full is decoded from the registered count, so a pop in the same cycle cannot admit a push.
  assign oQueueFull   = (oQueueCount == (FIFO_AW+1)'(DEPTH));
  assign push         = iCommandValid && !oQueueFull && !iFlush;
  assign overflow_set = iCommandValid && oQueueFull && !iFlush;

  assign core.oCmdValid = (state == ISSUE);
  assign oBusy          = (state != IDLE);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    handshake  = 1'b0;
    done_evt   = 1'b0;
    fail_evt   = 1'b0;
    abort_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (oQueueCount != '0 && !iFlush) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (core.iCmdReady) begin
          handshake  = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // A completion in the same cycle as watchdog expiry counts as a normal completion.
        if (core.iCmdDone) begin
          done_evt   = 1'b1;
          fail_evt   = core.iCmdFail;
          state_next = IDLE;
        end else if (wdog_expired) begin
          abort_evt  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {iCommand, iAddress, iLength};
  end

  // Flush only empties the queue; a command already handed to ISSUE/WAIT carries on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      oQueueCount <= '0;
    end else if (iFlush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      oQueueCount <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      oQueueCount <= oQueueCount + 1'b1;
      else if (pop && !push) oQueueCount <= oQueueCount - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core.oCmd  <= '0;
      core.oAddr <= '0;
      core.oLen  <= '0;
      oDoneCount <= '0;
      oFailCmd   <= '0;
      oOverflow  <= 1'b0;
      oFail      <= 1'b0;
    end else begin
      if (pop) {core.oCmd, core.oAddr, core.oLen} <= mem[rd_ptr];
      if (done_evt || abort_evt) oDoneCount <= oDoneCount + 1'b1;
      if (fail_evt || abort_evt) oFailCmd <= core.oCmd;
      if (overflow_set) oOverflow <= 1'b1;
      else if (iClear)  oOverflow <= 1'b0;
      if (fail_evt)     oFail <= 1'b1;
      else if (iClear)  oFail <= 1'b0;
    end
  end

`ifdef NFC_SCHED_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wdog;

  assign wdog_expired = (state == WAIT) && (wdog == TIMEOUT_CYCLES - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog     <= '0;
      oAbort   <= 1'b0;
      oTimeout <= 1'b0;
    end else begin
      if (handshake)          wdog <= '0;
      else if (state == WAIT) wdog <= wdog + 1'b1;
      oAbort <= abort_evt;
      if (abort_evt)   oTimeout <= 1'b1;
      else if (iClear) oTimeout <= 1'b0;
    end
  end
`else
  assign wdog_expired = 1'b0;
  assign oTimeout     = 1'b0;
  assign oAbort       = 1'b0;
`endif

endmodule

// File: tb/tb_nfc_cmd_scheduler.sv
// Self-checking bench for nfc_cmd_scheduler: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_nfc_cmd_scheduler;

  localparam int FIFO_AW = 3;
  localparam int DEPTH   = 8;
  localparam int TMO     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       iCommand;
  logic [31:0]       iAddress;
  logic [15:0]       iLength;
  logic              iCommandValid;
  logic              iFlush;
  logic              iClear;
  logic              oBusy;
  logic [FIFO_AW:0]  oQueueCount;
  logic              oQueueFull;
  logic              oOverflow;
  logic              oFail;
  logic [31:0]       oFailCmd;
  logic              oTimeout;
  logic              oAbort;
  logic [15:0]       oDoneCount;

  nfc_cmd_scheduler_if core_if ();

  nfc_cmd_scheduler #(
    .FIFO_AW(FIFO_AW),
    .TIMEOUT_W(24),
    .TIMEOUT_CYCLES(24'(TMO))
  ) dut (
    .clk(clk),
    .rst(rst),
    .iCommand(iCommand),
    .iAddress(iAddress),
    .iLength(iLength),
    .iCommandValid(iCommandValid),
    .iFlush(iFlush),
    .iClear(iClear),
    .core(core_if),
    .oBusy(oBusy),
    .oQueueCount(oQueueCount),
    .oQueueFull(oQueueFull),
    .oOverflow(oOverflow),
    .oFail(oFail),
    .oFailCmd(oFailCmd),
    .oTimeout(oTimeout),
    .oAbort(oAbort),
    .oDoneCount(oDoneCount)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: every accepted command not yet completed, in order.
  logic [79:0] model_q[$];
  logic [15:0] model_done;
  logic        model_fail;
  logic        model_overflow;
  logic        model_timeout;
  logic [31:0] model_fail_cmd;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    model_done     = '0;
    model_fail     = 1'b0;
    model_overflow = 1'b0;
    model_timeout  = 1'b0;
    model_fail_cmd = '0;
  endtask

  // One-cycle push; expect_accept tells the model whether the entry should land in the queue.
  task automatic applyStimulus(input logic [31:0] cmd, input logic [31:0] addr,
                               input logic [15:0] len, input bit expect_accept);
    iCommand      = cmd;
    iAddress      = addr;
    iLength       = len;
    iCommandValid = 1'b1;
    @(negedge clk);
    iCommandValid = 1'b0;
    if (expect_accept) model_q.push_back({cmd, addr, len});
    else model_overflow = 1'b1;
  endtask

  task automatic clearFlags();
    iClear = 1'b1;
    @(negedge clk);
    iClear = 1'b0;
    model_fail     = 1'b0;
    model_overflow = 1'b0;
    model_timeout  = 1'b0;
  endtask

  // Wait for the next issue, compare against the oldest pending model entry, then handshake.
  task automatic acceptNext(input int ready_delay);
    int waited;
    logic [79:0] exp;
    waited = 0;
    while (!core_if.oCmdValid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("issue_seen", core_if.oCmdValid, 1);
    if (core_if.oCmdValid) begin
      exp = (model_q.size() > 0) ? model_q[0] : '0;
      checkOutput("issue_cmd",  core_if.oCmd,  exp[79:48]);
      checkOutput("issue_addr", core_if.oAddr, exp[47:16]);
      checkOutput("issue_len",  core_if.oLen,  exp[15:0]);
      for (int i = 0; i < ready_delay; i++) begin
        @(negedge clk);
        checkOutput("hold_valid", core_if.oCmdValid, 1);
        checkOutput("hold_cmd",   core_if.oCmd, exp[79:48]);
      end
      core_if.iCmdReady = 1'b1;
      @(negedge clk);
      core_if.iCmdReady = 1'b0;
      checkOutput("valid_drop", core_if.oCmdValid, 0);
      checkOutput("busy_wait",  oBusy, 1);
    end
  endtask

  task automatic completeCmd(input int done_delay, input bit fail, input bit clear);
    logic [79:0] front;
    repeat (done_delay) @(negedge clk);
    core_if.iCmdDone = 1'b1;
    core_if.iCmdFail = fail;
    iClear           = clear;
    @(negedge clk);
    core_if.iCmdDone = 1'b0;
    core_if.iCmdFail = 1'b0;
    iClear           = 1'b0;
    front = (model_q.size() > 0) ? model_q.pop_front() : '0;
    model_done++;
    if (clear) begin
      model_fail     = 1'b0;
      model_overflow = 1'b0;
      model_timeout  = 1'b0;
    end
    if (fail) begin
      model_fail     = 1'b1;
      model_fail_cmd = front[79:48];
    end
    checkOutput("busy_after_done", oBusy, 0);
    checkOutput("done_count", oDoneCount, model_done);
    checkOutput("fail_flag",  oFail, model_fail);
    checkOutput("fail_cmd",   oFailCmd, model_fail_cmd);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int peak;
    int n;
    int k;
    logic [31:0] tcmd;

    iCommand = '0; iAddress = '0; iLength = '0;
    iCommandValid = 1'b0; iFlush = 1'b0; iClear = 1'b0;
    core_if.iCmdReady = 1'b0; core_if.iCmdDone = 1'b0; core_if.iCmdFail = 1'b0;
    modelReset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",   oBusy, 0);
    checkOutput("rst_count",  oQueueCount, 0);
    checkOutput("rst_valid",  core_if.oCmdValid, 0);
    checkOutput("rst_cmd",    core_if.oCmd, 0);
    checkOutput("rst_done",   oDoneCount, 0);
    checkOutput("rst_ovf",    oOverflow, 0);
    checkOutput("rst_tmo",    oTimeout, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single command");
    applyStimulus(32'h0000_0090, 32'h0000_1234, 16'd8, 1);
    checkOutput("single_count1", oQueueCount, 1);
    checkOutput("single_novalid", core_if.oCmdValid, 0);
    @(negedge clk);
    checkOutput("single_valid", core_if.oCmdValid, 1);
    checkOutput("single_count0", oQueueCount, 0);
    acceptNext(0);
    completeCmd(4, 0, 0);

    $display("[TB] done outside WAIT is ignored");
    core_if.iCmdDone = 1'b1;
    @(negedge clk);
    core_if.iCmdDone = 1'b0;
    @(negedge clk);
    checkOutput("stray_done", oDoneCount, model_done);

    $display("[TB] back-to-back");
    peak = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h100 + 32'(i), 32'h2000 + 32'(i), 16'(i + 1), 1);
      if (int'(oQueueCount) > peak) peak = int'(oQueueCount);
    end
    checkOutput("b2b_peak", 64'(peak), 2);
    for (int i = 0; i < 3; i++) begin
      acceptNext(1);
      completeCmd(1, 0, 0);
    end

    $display("[TB] overflow");
    applyStimulus($urandom, $urandom, 16'($urandom), 1);
    acceptNext(0);
    for (int i = 0; i < 10; i++)
      applyStimulus($urandom, $urandom, 16'($urandom), i < DEPTH);
    checkOutput("ovf_count", oQueueCount, DEPTH);
    checkOutput("ovf_full",  oQueueFull, 1);
    checkOutput("ovf_flag",  oOverflow, model_overflow);
    clearFlags();
    checkOutput("ovf_clear", oOverflow, model_overflow);
    completeCmd(0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      acceptNext($urandom_range(0, 2));
      completeCmd($urandom_range(0, 3), 0, 0);
    end
    repeat (3) @(negedge clk);
    checkOutput("ovf_no_extra_issue", core_if.oCmdValid, 0);
    checkOutput("ovf_empty", oQueueCount, 0);

    $display("[TB] fail with same-cycle clear");
    applyStimulus(32'h0000_00D0, 32'h0000_4000, 16'd16, 1);
    acceptNext(0);
    completeCmd(2, 1, 1);
    clearFlags();
    checkOutput("fail_cleared", oFail, model_fail);
    checkOutput("fail_cmd_kept", oFailCmd, model_fail_cmd);

    $display("[TB] watchdog");
    tcmd = $urandom;
    applyStimulus(tcmd, $urandom, 16'($urandom), 1);
    acceptNext(0);
`ifdef NFC_SCHED_TIMEOUT_EN
    k = 0;
    for (int i = 1; i <= 3 * TMO; i++) begin
      @(negedge clk);
      if (oAbort) begin
        k = i;
        break;
      end
    end
    checkOutput("abort_cycle", 64'(k), TMO);
    void'(model_q.pop_front());
    model_done++;
    model_timeout  = 1'b1;
    model_fail_cmd = tcmd;
    checkOutput("tmo_flag", oTimeout, model_timeout);
    checkOutput("tmo_busy", oBusy, 0);
    checkOutput("tmo_fail_cmd", oFailCmd, model_fail_cmd);
    checkOutput("tmo_done", oDoneCount, model_done);
    @(negedge clk);
    checkOutput("abort_one_cycle", oAbort, 0);
`else
    k = 0;
    repeat (3 * TMO) begin
      @(negedge clk);
      if (oAbort) k++;
    end
    checkOutput("no_abort", 64'(k), 0);
    checkOutput("stay_wait", oBusy, 1);
    checkOutput("no_tmo", oTimeout, 0);
    completeCmd(0, 0, 0);
`endif

    $display("[TB] flush");
    applyStimulus($urandom, $urandom, 16'($urandom), 1);
    acceptNext(0);
    for (int i = 0; i < 3; i++)
      applyStimulus($urandom, $urandom, 16'($urandom), 1);
    checkOutput("flush_pre_count", oQueueCount, 3);
    iFlush = 1'b1;
    iCommandValid = 1'b1;
    iCommand = $urandom;
    @(negedge clk);
    iFlush = 1'b0;
    iCommandValid = 1'b0;
    while (model_q.size() > 1) void'(model_q.pop_back());
    checkOutput("flush_count", oQueueCount, 0);
    checkOutput("flush_busy", oBusy, 1);
    completeCmd(2, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("flush_no_issue", core_if.oCmdValid, 0);

    $display("[TB] reset mid-issue");
    applyStimulus(32'hCAFE_0001, 32'h0000_0777, 16'd4, 1);
    @(negedge clk);
    checkOutput("pre_rst_valid", core_if.oCmdValid, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_valid", core_if.oCmdValid, 0);
    checkOutput("async_cmd",   core_if.oCmd, 0);
    checkOutput("async_busy",  oBusy, 0);
    checkOutput("async_done",  oDoneCount, 0);
    checkOutput("async_failcmd", oFailCmd, 0);
    checkOutput("async_abort", oAbort, 0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    @(negedge clk);
    checkOutput("post_rst_count", oQueueCount, 0);

    $display("[TB] randomized traffic");
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        applyStimulus($urandom, $urandom, 16'($urandom), 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      for (int i = 0; i < n; i++) begin
        acceptNext($urandom_range(0, 3));
        completeCmd($urandom_range(0, 4), $urandom_range(0, 3) == 0, 0);
      end
    end
    checkOutput("rand_final_count", oQueueCount, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
